uart_slave: RTL

Memory-mapped 8N1 UART peripheral occupying the 0xfa00–0xfa0f slave window of the system bus; only address bit 0 is decoded.
- Converts single-cycle bus reads/writes into serial TX/RX traffic through one TX FIFO and one RX FIFO.
- Raises a level interrupt toward the CPU interrupt logic.
- Pulses a system-reset request when a line break is received, so a host can reset the machine over the serial link.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_slave.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Register map, status bit indices and FSM states for uart_slave.
//  Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam logic UART_REG_STATUS = 1'b0;
    localparam logic UART_REG_DATA   = 1'b1;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_IDLE  = 2;
    localparam int STAT_OVERRUN  = 3;
    localparam int STAT_FRAME    = 4;
    localparam int STAT_RXIE     = 5;
    localparam int STAT_TXIE     = 6;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, combinational head, extra-bit pointer wrap.
//  Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (wptr_q == rptr_q);
    assign o_full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + 1'b1;
            if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_slave.sv
`default_nettype none
// ============================================================================
//  Module      : uart_slave
//  Description : Bus-mapped 8N1 UART with TX/RX FIFOs, interrupt, break reset.
//  Revision    : 1.0
// ============================================================================
module uart_slave
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_cs,
    input  logic       i_we,
    output logic       o_ack,
    output logic       o_int,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_reset
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic w_rx_pop, w_tx_push, w_stat_rd, w_ctrl_wr, w_tx_pop;
    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_tx_idle;
    logic [7:0] w_rx_rdata, w_tx_rdata, w_status;
    logic w_rx_sample, w_rx_push, w_frame_err, w_overrun;

    uart_state_e      rx_state_q, tx_state_q;
    logic             rx_meta_q, rx_line_q, rx_wait_q, reset_q;
    logic [CNT_W-1:0] rx_cnt_q, tx_cnt_q;
    logic [2:0]       rx_bit_q, tx_bit_q;
    logic [7:0]       rx_shift_q, tx_shift_q;
    logic             tx_q, rxie_q, txie_q, ovr_q, ferr_q;

    assign w_rx_pop  = i_cs & ~i_we & (i_addr == UART_REG_DATA);
    assign w_stat_rd = i_cs & ~i_we & (i_addr == UART_REG_STATUS);
    assign w_tx_push = i_cs &  i_we & (i_addr == UART_REG_DATA);
    assign w_ctrl_wr = i_cs &  i_we & (i_addr == UART_REG_STATUS);

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_wdata(rx_shift_q), .o_rdata(w_rx_rdata), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_wdata(i_dat), .o_rdata(w_tx_rdata), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    assign w_rx_sample = (rx_state_q == S_STOP) & ~rx_wait_q & (rx_cnt_q == '0);
    assign w_rx_push   = w_rx_sample & rx_line_q;
    assign w_frame_err = w_rx_sample & ~rx_line_q;
    assign w_overrun   = w_rx_push & w_rx_full & ~w_rx_pop;
    assign w_tx_idle   = w_tx_empty & (tx_state_q == S_IDLE);
    assign w_tx_pop    = ~w_tx_empty & ((tx_state_q == S_IDLE) |
                                        ((tx_state_q == S_STOP) & (tx_cnt_q == '0)));

    always_comb begin
        w_status                = 8'h00;
        w_status[STAT_RX_VALID] = ~w_rx_empty;
        w_status[STAT_TX_FULL]  = w_tx_full;
        w_status[STAT_TX_IDLE]  = w_tx_idle;
        w_status[STAT_OVERRUN]  = ovr_q;
        w_status[STAT_FRAME]    = ferr_q;
        w_status[STAT_RXIE]     = rxie_q;
        w_status[STAT_TXIE]     = txie_q;
    end

    assign o_dat   = (i_addr == UART_REG_DATA) ? (w_rx_empty ? 8'h00 : w_rx_rdata) : w_status;
    assign o_ack   = i_cs;
    assign o_int   = (rxie_q & ~w_rx_empty) | (txie_q & w_tx_empty);
    assign o_tx    = tx_q;
    assign o_reset = reset_q;

    // Sticky flags: a new error in the clearing cycle survives the clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                rxie_q <= i_dat[0];
                txie_q <= i_dat[1];
            end
            ovr_q  <= (ovr_q  & ~w_stat_rd) | w_overrun;
            ferr_q <= (ferr_q & ~w_stat_rd) | w_frame_err;
        end
    end

    // IDLE is only entered with the line high, so a low level there is a falling edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q  <= 1'b1;
            rx_line_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_wait_q  <= 1'b0;
            reset_q    <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_line_q <= rx_meta_q;
            reset_q   <= 1'b0;
            case (rx_state_q)
                S_IDLE: if (!rx_line_q) begin
                    rx_state_q <= S_START;
                    rx_cnt_q   <= HALF_LAST;
                end
                S_START: if (rx_cnt_q != '0) begin
                    rx_cnt_q <= rx_cnt_q - 1'b1;
                end else if (rx_line_q) begin
                    rx_state_q <= S_IDLE;
                end else begin
                    rx_state_q <= S_DATA;
                    rx_cnt_q   <= BIT_LAST;
                    rx_bit_q   <= '0;
                end
                S_DATA: if (rx_cnt_q != '0) begin
                    rx_cnt_q <= rx_cnt_q - 1'b1;
                end else begin
                    rx_shift_q <= {rx_line_q, rx_shift_q[7:1]};
                    rx_cnt_q   <= BIT_LAST;
                    if (rx_bit_q == LAST_BIT) rx_state_q <= S_STOP;
                    else                      rx_bit_q   <= rx_bit_q + 1'b1;
                end
                S_STOP: if (rx_wait_q) begin
                    if (rx_line_q) begin
                        rx_wait_q  <= 1'b0;
                        rx_state_q <= S_IDLE;
                    end
                end else if (rx_cnt_q != '0) begin
                    rx_cnt_q <= rx_cnt_q - 1'b1;
                end else begin
                    rx_wait_q <= 1'b1;
                    reset_q   <= ~rx_line_q & (rx_shift_q == 8'h00);
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (w_tx_pop) begin
                    tx_shift_q <= w_tx_rdata;
                    tx_q       <= 1'b0;
                    tx_cnt_q   <= BIT_LAST;
                    tx_state_q <= S_START;
                end
                S_START: if (tx_cnt_q != '0) begin
                    tx_cnt_q <= tx_cnt_q - 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= '0;
                    tx_cnt_q   <= BIT_LAST;
                    tx_state_q <= S_DATA;
                end
                S_DATA: if (tx_cnt_q != '0) begin
                    tx_cnt_q <= tx_cnt_q - 1'b1;
                end else begin
                    tx_cnt_q <= BIT_LAST;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_q       <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= tx_bit_q + 1'b1;
                    end
                end
                S_STOP: if (tx_cnt_q != '0) begin
                    tx_cnt_q <= tx_cnt_q - 1'b1;
                end else if (w_tx_pop) begin
                    tx_shift_q <= w_tx_rdata;
                    tx_q       <= 1'b0;
                    tx_cnt_q   <= BIT_LAST;
                    tx_state_q <= S_START;
                end else begin
                    tx_state_q <= S_IDLE;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
